// File: rtl/mem_responder.sv
// Word-addressed memory responder with a fixed number of wait states per access.
// One access in flight at a time; completion signalled by a single-cycle ready pulse.
module mem_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 512
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        read,
  input  logic        write,
  input  logic [8:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q;
  logic [3:0]     cnt_q;
  logic [AW-1:0]  addr_q;
  logic [31:0]    wdata_q;
  logic           is_wr_q;
  logic [31:0]    rdata_q;
  logic           ready_q;
  logic           busy_q;
  logic           err_q;
  logic           commit_wr_d;

  // Array contents are never reset: storage survives clr.
  logic [31:0]    mem_q [DEPTH];

  // Write lands on the WAIT->DONE edge unless clr aborts that same edge.
  assign commit_wr_d = !clr && (state_q == ST_WAIT) && (cnt_q == 4'd0) && is_wr_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read ^ write) begin
            addr_q  <= addr[AW-1:0];
            wdata_q <= wdata;
            is_wr_q <= write;
            cnt_q   <= CNT_LOAD;
            busy_q  <= 1'b1;
            state_q <= ST_WAIT;
          end else if (read && write) begin
            err_q <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            ready_q <= 1'b1;
            state_q <= ST_DONE;
            if (!is_wr_q) begin
              rdata_q <= mem_q[addr_q];
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (commit_wr_d) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level reference model.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk;
  logic        clr;
  logic        rd;
  logic        wr;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        err;

  int checks;
  int failures;

  // reference model state
  int          t;
  bit          inflight;
  int          acc;
  bit          op_wr;
  int          m_addr;
  logic [31:0] m_wdata;
  logic [31:0] mem_m [512];
  bit          known [512];
  logic [31:0] rdata_e;
  bit          rvalid;
  bit          busy_e;
  bit          ready_e;
  bit          err_e;
  int          ready_seen;

  mem_responder #(.LATENCY(LAT), .DEPTH(512)) dut (
    .clk   (clk),
    .clr   (clr),
    .read  (rd),
    .write (wr),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Accept at edge a: busy after edges a..a+LAT, ready and commit at edge a+LAT,
  // next request sampled at edge a+LAT+2 at the earliest.
  task model_step();
    if (clr) begin
      inflight = 0;
      rdata_e  = 32'd0;
      rvalid   = 1;
      err_e    = 0;
    end else begin
      err_e = 0;
      if (inflight && t == acc + LAT) begin
        if (op_wr) begin
          mem_m[m_addr] = m_wdata;
          known[m_addr] = 1;
        end else begin
          rdata_e = mem_m[m_addr];
          rvalid  = known[m_addr];
        end
      end
      if (!inflight || t >= acc + LAT + 2) begin
        inflight = 0;
        if (rd ^ wr) begin
          inflight = 1;
          acc      = t;
          op_wr    = wr;
          m_addr   = int'(addr);
          m_wdata  = wdata;
        end else if (rd && wr) begin
          err_e = 1;
        end
      end
    end
    busy_e  = inflight && (t <= acc + LAT);
    ready_e = inflight && (t == acc + LAT);
  endtask

  task automatic cycle(input logic c, input logic r, input logic w,
                       input logic [8:0] a, input logic [31:0] d);
    clr   = c;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    @(posedge clk);
    t++;
    model_step();
    @(negedge clk);
    if (ready) ready_seen++;
    check("busy",  {31'd0, busy},  {31'd0, busy_e});
    check("ready", {31'd0, ready}, {31'd0, ready_e});
    check("err",   {31'd0, err},   {31'd0, err_e});
    if (rvalid) check("rdata", rdata, rdata_e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    t          = 0;
    inflight   = 0;
    acc        = 0;
    rvalid     = 0;
    ready_seen = 0;
    for (int i = 0; i < 512; i++) known[i] = 0;

    // reset, then write 0xDEADBEEF to 0x005 and read it back
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    check("rst_rdata", rdata, 32'd0);
    cycle(1'b0, 1'b0, 1'b1, 9'h005, 32'hDEADBEEF);
    idle(LAT + 2);
    cycle(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
    idle(LAT + 2);
    check("read_005", rdata, 32'hDEADBEEF);
    idle(3);
    check("read_005_hold", rdata, 32'hDEADBEEF);

    // simultaneous read+write is rejected
    cycle(1'b0, 1'b1, 1'b1, 9'h005, 32'h0BAD0BAD);
    idle(LAT + 2);
    cycle(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
    idle(LAT + 2);
    check("both_mem_kept", rdata, 32'hDEADBEEF);

    // inputs changing during WAIT do not disturb the access; last word addressable
    cycle(1'b0, 1'b0, 1'b1, 9'h000, 32'h11111111);
    idle(LAT + 2);
    cycle(1'b0, 1'b0, 1'b1, 9'h1FF, 32'h12345678);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 32'hFFFFFFFF);
    cycle(1'b0, 1'b0, 1'b0, 9'h000, 32'hFFFFFFFF);
    idle(LAT);
    cycle(1'b0, 1'b1, 1'b0, 9'h1FF, 32'h0);
    idle(LAT + 2);
    check("read_1ff", rdata, 32'h12345678);
    cycle(1'b0, 1'b1, 1'b0, 9'h000, 32'h0);
    idle(LAT + 2);
    check("read_000", rdata, 32'h11111111);

    // clr in the first WAIT cycle aborts a write
    cycle(1'b0, 1'b0, 1'b1, 9'h010, 32'h0BADBEEF);
    idle(LAT + 2);
    cycle(1'b0, 1'b0, 1'b1, 9'h010, 32'hCAFEF00D);
    cycle(1'b1, 1'b0, 1'b0, 9'h010, 32'hCAFEF00D);
    check("abort_rdata", rdata, 32'd0);
    idle(LAT + 2);
    cycle(1'b0, 1'b1, 1'b0, 9'h010, 32'h0);
    idle(LAT + 2);
    check("read_010", rdata, 32'h0BADBEEF);

    // clr on the WAIT->DONE edge of a read leaves rdata cleared
    cycle(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 9'h0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 9'h0, 32'h0);
    check("late_clr_rdata", rdata, 32'd0);
    idle(2);

    // read held for 12 cycles gives exactly three completions
    ready_seen = 0;
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 9'h005, 32'h0);
    idle(LAT + 2);
    check("held_ready_cnt", ready_seen, 32'd3);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      int op;
      logic [8:0] a;
      r  = $urandom_range(0, 15);
      a  = (r == 15) ? 9'h1FF : 9'(r);
      op = $urandom_range(0, 9);
      cycle(($urandom_range(0, 49) == 0), (op < 4) || (op == 8), (op >= 4 && op < 8) || (op == 8),
            a, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
